pc_seq_ctrl: RTL and testbench

- Multi-cycle fetch/PC sequencer for the MIPS-Lite3 datapath.
- Owns the architectural PC register and the instruction register, and runs the instruction-memory fetch handshake.
- Decodes the branch/jump class of each instruction into the 2-bit next-PC select for the next-PC unit.
- Commits the next-PC unit's result into PC once the datapath reports execute completion.

---
 rtl/pc_seq_ctrl.sv | 123 ++++++++++++
 tb/tb_pc_seq_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_seq_ctrl.sv
// pc_seq_ctrl - multi-cycle fetch / PC sequencer for the MIPS-Lite3 datapath.
//
// Owns the architectural PC and the instruction register, runs the
// instruction-memory fetch handshake, classifies each instruction into the
// next-PC select, and commits the next-PC unit's result once execution is done.
//
// One instruction walks FETCH -> WAIT -> DECODE -> EXEC -> UPDATE -> FETCH.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   imem_req     fetch request, high for the whole WAIT residency
//   imem_addr    fetch word address (always equals pc)
//   imem_ack     memory response strobe, only honoured in WAIT
//   imem_rdata   fetched instruction
//   ir           instruction register, stable from DECODE through UPDATE
//   pc           current PC word address [31:2]
//   npc_sel      next-PC select: 00 seq, 01 beq, 10 j/jal, 11 jr
//   npc_in       next-PC word address from the next-PC unit
//   ex_start     one-cycle pulse starting datapath execution
//   ex_done      execution finished, sampled only in EXEC
//   hold         external stall, blocks the PC commit in UPDATE
//   pc_we        high in the cycle PC is written
//   retired      committed-instruction count, wraps modulo 2^CNT_W
//   state_o      current FSM state for debug
module pc_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [29:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ir,
    output logic [29:0]      pc,
    output logic [1:0]       npc_sel,
    input  logic [29:0]      npc_in,
    output logic             ex_start,
    input  logic             ex_done,
    input  logic             hold,
    output logic             pc_we,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       state_o
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_WAIT   = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_UPDATE = 3'd4
    } state_t;

    state_t state;
    state_t state_nxt;
    logic   commit;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Branch/jump class of an instruction -> next-PC select.
    function automatic logic [1:0] decode_npc_sel(input logic [31:0] instr);
        logic [1:0] sel;
        sel = 2'b00;
        case (instr[31:26])
            6'b000100: sel = 2'b01;
            6'b000010,
            6'b000011: sel = 2'b10;
            6'b000000: if (instr[5:0] == 6'b001000) sel = 2'b11;
            default:   sel = 2'b00;
        endcase
        return sel;
    endfunction

    // Next-state logic; unused encodings fall back to FETCH.
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:  state_nxt = S_WAIT;
            S_WAIT:   if (imem_ack) state_nxt = S_DECODE;
            S_DECODE: state_nxt = S_EXEC;
            S_EXEC:   if (ex_done) state_nxt = S_UPDATE;
            S_UPDATE: if (!hold) state_nxt = S_FETCH;
            default:  state_nxt = S_FETCH;
        endcase
    end

    // The commit strobe is combinational so pc_we lines up with the PC write edge.
    assign commit    = (state == S_UPDATE) && !hold;
    assign pc_we     = commit;
    assign imem_addr = pc;
    assign state_o   = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_FETCH;
            imem_req <= 1'b0;
            ex_start <= 1'b0;
            ir       <= 32'h0;
            npc_sel  <= 2'b00;
            pc       <= RESET_PC[31:2];
            retired  <= '0;
        end else begin
            state    <= state_nxt;
            // Request is high exactly while the FSM sits in WAIT.
            imem_req <= (state_nxt == S_WAIT);
            // Pulse lands in the first EXEC cycle.
            ex_start <= (state == S_DECODE);
            if ((state == S_WAIT) && imem_ack) begin
                ir <= imem_rdata;
            end
            if (state == S_DECODE) begin
                npc_sel <= decode_npc_sel(ir);
            end
            if (commit) begin
                pc      <= npc_in;
                retired <= retired + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// Directed testbench for pc_seq_ctrl (CNT_W = 4 so the counter wrap is reachable).
module tb_pc_seq_ctrl;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             imem_req;
    logic [29:0]      imem_addr;
    logic             imem_ack;
    logic [31:0]      imem_rdata;
    logic [31:0]      ir;
    logic [29:0]      pc;
    logic [1:0]       npc_sel;
    logic [29:0]      npc_in;
    logic             ex_start;
    logic             ex_done;
    logic             hold;
    logic             pc_we;
    logic [CNT_W-1:0] retired;
    logic [2:0]       state_o;

    int tests  = 0;
    int failed = 0;

    logic [29:0] exp_pc;
    int          exp_ret;

    localparam logic [2:0] ST_FETCH = 3'd0, ST_WAIT = 3'd1, ST_DECODE = 3'd2,
                           ST_EXEC = 3'd3, ST_UPDATE = 3'd4;

    pc_seq_ctrl #(.RESET_PC(32'h0000_3000), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .ir(ir), .pc(pc), .npc_sel(npc_sel),
        .npc_in(npc_in), .ex_start(ex_start), .ex_done(ex_done), .hold(hold),
        .pc_we(pc_we), .retired(retired), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One instruction with zero-wait memory, 1-cycle execute and no hold.
    // Entered and left in FETCH.
    task automatic run_instr(input logic [31:0] instr, input logic [29:0] npc,
                             input logic [1:0] sel);
        check("in_fetch", {29'h0, state_o}, {29'h0, ST_FETCH});
        step();
        check("wait_state", {29'h0, state_o}, {29'h0, ST_WAIT});
        check("wait_req", {31'h0, imem_req}, 32'h1);
        check("wait_addr", {2'b0, imem_addr}, {2'b0, exp_pc});
        imem_ack = 1'b1; imem_rdata = instr;
        step();
        imem_ack = 1'b0; imem_rdata = 32'hDEAD_BEEF;
        check("dec_state", {29'h0, state_o}, {29'h0, ST_DECODE});
        check("dec_ir", ir, instr);
        check("dec_req", {31'h0, imem_req}, 32'h0);
        ex_done = 1'b1;
        step();
        check("exec_state", {29'h0, state_o}, {29'h0, ST_EXEC});
        check("exec_start", {31'h0, ex_start}, 32'h1);
        check("exec_sel", {30'h0, npc_sel}, {30'h0, sel});
        step();
        ex_done = 1'b0;
        npc_in  = npc;
        check("upd_state", {29'h0, state_o}, {29'h0, ST_UPDATE});
        check("upd_sel", {30'h0, npc_sel}, {30'h0, sel});
        check("upd_ir", ir, instr);
        check("upd_we", {31'h0, pc_we}, 32'h1);
        check("upd_start", {31'h0, ex_start}, 32'h0);
        step();
        exp_pc  = npc;
        exp_ret = (exp_ret + 1) % 16;
        check("post_state", {29'h0, state_o}, {29'h0, ST_FETCH});
        check("post_pc", {2'b0, pc}, {2'b0, exp_pc});
        check("post_ret", {28'h0, retired}, exp_ret);
        check("post_we", {31'h0, pc_we}, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 32'h0;
        npc_in = 30'h0; ex_done = 1'b0; hold = 1'b0;
        exp_pc = 30'h0C00; exp_ret = 0;
        #12;
        // Reset values
        check("rst_state", {29'h0, state_o}, {29'h0, ST_FETCH});
        check("rst_pc", {2'b0, pc}, 32'h0000_0C00);
        check("rst_ir", ir, 32'h0);
        check("rst_sel", {30'h0, npc_sel}, 32'h0);
        check("rst_ret", {28'h0, retired}, 32'h0);
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_start", {31'h0, ex_start}, 32'h0);
        check("rst_we", {31'h0, pc_we}, 32'h0);
        rst_n = 1'b1;
        #1;

        // Sequential addiu at 0x3000
        run_instr(32'h2408_0001, 30'h0C01, 2'b00);

        // Decode classes
        run_instr(32'h1000_0003, 30'h0C05, 2'b01);   // beq
        run_instr(32'h0800_0C10, 30'h0C10, 2'b10);   // j
        run_instr(32'h0C00_0C10, 30'h0C10, 2'b10);   // jal
        run_instr(32'h03E0_0008, 30'h0C20, 2'b11);   // jr $31
        run_instr(32'h0000_0020, 30'h0C21, 2'b00);   // add

        // Memory wait, slow execute, hold in UPDATE
        hold = 1'b1;                                 // no effect outside UPDATE
        step();
        check("mw_state", {29'h0, state_o}, {29'h0, ST_WAIT});
        for (int i = 0; i < 4; i++) begin
            step();
            check("mw_wait", {29'h0, state_o}, {29'h0, ST_WAIT});
            check("mw_req", {31'h0, imem_req}, 32'h1);
            check("mw_ir", ir, 32'h0000_0020);
        end
        imem_ack = 1'b1; imem_rdata = 32'h1000_FFFF;
        step();
        imem_ack = 1'b0;
        check("mw_ir_cap", ir, 32'h1000_FFFF);
        check("mw_req_drop", {31'h0, imem_req}, 32'h0);
        step();
        check("slow_start", {31'h0, ex_start}, 32'h1);
        // Stray memory response during EXEC must not touch ir
        imem_ack = 1'b1; imem_rdata = 32'h0800_0001;
        for (int i = 0; i < 3; i++) begin
            step();
            check("slow_exec", {29'h0, state_o}, {29'h0, ST_EXEC});
            check("slow_start0", {31'h0, ex_start}, 32'h0);
        end
        imem_ack = 1'b0;
        check("stray_ir", ir, 32'h1000_FFFF);
        ex_done = 1'b1;
        npc_in  = 30'h0C40;
        step();
        ex_done = 1'b0;
        check("hold_upd", {29'h0, state_o}, {29'h0, ST_UPDATE});
        check("hold_sel", {30'h0, npc_sel}, 32'h1);
        check("hold_we0", {31'h0, pc_we}, 32'h0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("hold_stay", {29'h0, state_o}, {29'h0, ST_UPDATE});
            check("hold_we", {31'h0, pc_we}, 32'h0);
            check("hold_pc", {2'b0, pc}, 32'h0000_0C21);
        end
        hold = 1'b0;
        #1;
        check("hold_we1", {31'h0, pc_we}, 32'h1);
        step();
        exp_pc = 30'h0C40; exp_ret = 7;
        check("hold_pc_new", {2'b0, pc}, 32'h0000_0C40);
        check("hold_ret", {28'h0, retired}, 32'h7);
        check("hold_we_off", {31'h0, pc_we}, 32'h0);

        // Reset in WAIT, stale ack after release
        step();
        check("rmf_wait", {29'h0, state_o}, {29'h0, ST_WAIT});
        rst_n = 1'b0;
        #1;
        check("rmf_state", {29'h0, state_o}, {29'h0, ST_FETCH});
        check("rmf_pc", {2'b0, pc}, 32'h0000_0C00);
        check("rmf_ret", {28'h0, retired}, 32'h0);
        check("rmf_req", {31'h0, imem_req}, 32'h0);
        imem_ack = 1'b1; imem_rdata = 32'h0800_0777;
        #1;
        rst_n = 1'b1;
        step();
        imem_ack = 1'b0;
        check("rmf_ir", ir, 32'h0);
        check("rmf_new_req", {31'h0, imem_req}, 32'h1);
        check("rmf_state2", {29'h0, state_o}, {29'h0, ST_WAIT});
        check("rmf_addr", {2'b0, imem_addr}, 32'h0000_0C00);
        // Return cleanly to FETCH
        #2;
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        exp_pc = 30'h0C00; exp_ret = 0;

        // 17 commits wrap a 4-bit counter to 1; also PC wrap 3FFFFFFF -> 0
        run_instr(32'h2408_0001, 30'h3FFF_FFFF, 2'b00);
        run_instr(32'h0800_0000, 30'h0000_0000, 2'b10);
        for (int i = 0; i < 15; i++) begin
            run_instr(32'h0000_0020, 30'(i + 1), 2'b00);
        end
        check("wrap_ret", {28'h0, retired}, 32'h1);
        check("wrap_pc", {2'b0, pc}, 32'h0000_000F);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule
